// File: rtl/nvdla_dbb_ostd_limiter.sv
// Outstanding-transaction limiter between the NVDLA core AXI master and the DBB fabric.
// Gates AW/AR on registered outstanding counts and holds W data back until its AW has been accepted.
module nvdla_dbb_ostd_limiter #(
    parameter int MAX_WR_OSTD = 8,
    parameter int MAX_RD_OSTD = 16
) (
    input  logic        core_clk,
    input  logic        rstn,
    // core-side AXI slave
    input  logic        core_aw_awvalid,
    output logic        core_aw_awready,
    input  logic [7:0]  core_aw_awid,
    input  logic [3:0]  core_aw_awlen,
    input  logic [63:0] core_aw_awaddr,
    input  logic        core_w_wvalid,
    output logic        core_w_wready,
    input  logic [63:0] core_w_wdata,
    input  logic [7:0]  core_w_wstrb,
    input  logic        core_w_wlast,
    output logic        core_b_bvalid,
    input  logic        core_b_bready,
    output logic [7:0]  core_b_bid,
    input  logic        core_ar_arvalid,
    output logic        core_ar_arready,
    input  logic [7:0]  core_ar_arid,
    input  logic [3:0]  core_ar_arlen,
    input  logic [63:0] core_ar_araddr,
    output logic        core_r_rvalid,
    input  logic        core_r_rready,
    output logic [7:0]  core_r_rid,
    output logic        core_r_rlast,
    output logic [63:0] core_r_rdata,
    // fabric-side AXI master
    output logic        dbb_aw_awvalid,
    input  logic        dbb_aw_awready,
    output logic [7:0]  dbb_aw_awid,
    output logic [3:0]  dbb_aw_awlen,
    output logic [63:0] dbb_aw_awaddr,
    output logic        dbb_w_wvalid,
    input  logic        dbb_w_wready,
    output logic [63:0] dbb_w_wdata,
    output logic [7:0]  dbb_w_wstrb,
    output logic        dbb_w_wlast,
    input  logic        dbb_b_bvalid,
    output logic        dbb_b_bready,
    input  logic [7:0]  dbb_b_bid,
    output logic        dbb_ar_arvalid,
    input  logic        dbb_ar_arready,
    output logic [7:0]  dbb_ar_arid,
    output logic [3:0]  dbb_ar_arlen,
    output logic [63:0] dbb_ar_araddr,
    input  logic        dbb_r_rvalid,
    output logic        dbb_r_rready,
    input  logic [7:0]  dbb_r_rid,
    input  logic        dbb_r_rlast,
    input  logic [63:0] dbb_r_rdata,
    // status
    output logic [4:0]  wr_ostd_cnt,
    output logic [4:0]  rd_ostd_cnt,
    output logic        ostd_err
);

    localparam logic [4:0] LP_WR_MAX = 5'(MAX_WR_OSTD);
    localparam logic [4:0] LP_RD_MAX = 5'(MAX_RD_OSTD);

    logic [4:0] r_wr_cnt;
    logic [4:0] r_rd_cnt;
    logic [4:0] r_wcred;
    logic       r_err;

    logic w_wr_ok, w_rd_ok, w_w_ok;
    logic w_aw_hs, w_wlast_hs, w_b_hs, w_ar_hs, w_rlast_hs;

    // Counters hold when inc and dec coincide and never wrap below zero.
    function automatic logic [4:0] f_next(input logic [4:0] cnt, input logic inc, input logic dec);
        logic [4:0] nxt;
        nxt = cnt;
        if (inc && !dec)
            nxt = cnt + 5'd1;
        else if (dec && !inc && cnt != 5'd0)
            nxt = cnt - 5'd1;
        return nxt;
    endfunction

    // Gates include rstn so no request leaks downstream while counts are being cleared.
    assign w_wr_ok = rstn & (r_wr_cnt < LP_WR_MAX);
    assign w_rd_ok = rstn & (r_rd_cnt < LP_RD_MAX);

    assign w_aw_hs    = core_aw_awvalid & dbb_aw_awready & w_wr_ok;
    assign w_w_ok     = rstn & ((r_wcred != 5'd0) | w_aw_hs);
    assign w_wlast_hs = core_w_wvalid & dbb_w_wready & w_w_ok & core_w_wlast;
    assign w_b_hs     = dbb_b_bvalid & core_b_bready;
    assign w_ar_hs    = core_ar_arvalid & dbb_ar_arready & w_rd_ok;
    assign w_rlast_hs = dbb_r_rvalid & core_r_rready & dbb_r_rlast;

    assign dbb_aw_awvalid  = core_aw_awvalid & w_wr_ok;
    assign core_aw_awready = dbb_aw_awready & w_wr_ok;
    assign dbb_aw_awid     = core_aw_awid;
    assign dbb_aw_awlen    = core_aw_awlen;
    assign dbb_aw_awaddr   = core_aw_awaddr;

    assign dbb_w_wvalid  = core_w_wvalid & w_w_ok;
    assign core_w_wready = dbb_w_wready & w_w_ok;
    assign dbb_w_wdata   = core_w_wdata;
    assign dbb_w_wstrb   = core_w_wstrb;
    assign dbb_w_wlast   = core_w_wlast;

    assign core_b_bvalid = dbb_b_bvalid;
    assign dbb_b_bready  = core_b_bready;
    assign core_b_bid    = dbb_b_bid;

    assign dbb_ar_arvalid  = core_ar_arvalid & w_rd_ok;
    assign core_ar_arready = dbb_ar_arready & w_rd_ok;
    assign dbb_ar_arid     = core_ar_arid;
    assign dbb_ar_arlen    = core_ar_arlen;
    assign dbb_ar_araddr   = core_ar_araddr;

    assign core_r_rvalid = dbb_r_rvalid;
    assign dbb_r_rready  = core_r_rready;
    assign core_r_rid    = dbb_r_rid;
    assign core_r_rlast  = dbb_r_rlast;
    assign core_r_rdata  = dbb_r_rdata;

    // NOTE: state uses non-blocking assignments so every counter samples the same pre-edge values.
    always_ff @(posedge core_clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_cnt <= 5'd0;
            r_rd_cnt <= 5'd0;
            r_wcred  <= 5'd0;
            r_err    <= 1'b0;
        end else begin
            r_wr_cnt <= f_next(r_wr_cnt, w_aw_hs, w_b_hs);
            r_rd_cnt <= f_next(r_rd_cnt, w_ar_hs, w_rlast_hs);
            r_wcred  <= f_next(r_wcred, w_aw_hs, w_wlast_hs);
            if ((w_b_hs && r_wr_cnt == 5'd0) || (w_rlast_hs && r_rd_cnt == 5'd0))
                r_err <= 1'b1;
        end
    end

    assign wr_ostd_cnt = r_wr_cnt;
    assign rd_ostd_cnt = r_rd_cnt;
    assign ostd_err    = r_err;

endmodule

// File: tb/tb_nvdla_dbb_ostd_limiter.sv
// Bench for nvdla_dbb_ostd_limiter: directed corner cases plus randomized traffic
// compared against an integer-count reference model.
module tb_nvdla_dbb_ostd_limiter;

    localparam int MAX_WR = 8;
    localparam int MAX_RD = 16;

    logic        core_clk = 1'b0;
    logic        rstn     = 1'b0;
    logic        core_aw_awvalid, core_aw_awready;
    logic [7:0]  core_aw_awid;
    logic [3:0]  core_aw_awlen;
    logic [63:0] core_aw_awaddr;
    logic        core_w_wvalid, core_w_wready;
    logic [63:0] core_w_wdata;
    logic [7:0]  core_w_wstrb;
    logic        core_w_wlast;
    logic        core_b_bvalid, core_b_bready;
    logic [7:0]  core_b_bid;
    logic        core_ar_arvalid, core_ar_arready;
    logic [7:0]  core_ar_arid;
    logic [3:0]  core_ar_arlen;
    logic [63:0] core_ar_araddr;
    logic        core_r_rvalid, core_r_rready;
    logic [7:0]  core_r_rid;
    logic        core_r_rlast;
    logic [63:0] core_r_rdata;
    logic        dbb_aw_awvalid, dbb_aw_awready;
    logic [7:0]  dbb_aw_awid;
    logic [3:0]  dbb_aw_awlen;
    logic [63:0] dbb_aw_awaddr;
    logic        dbb_w_wvalid, dbb_w_wready;
    logic [63:0] dbb_w_wdata;
    logic [7:0]  dbb_w_wstrb;
    logic        dbb_w_wlast;
    logic        dbb_b_bvalid, dbb_b_bready;
    logic [7:0]  dbb_b_bid;
    logic        dbb_ar_arvalid, dbb_ar_arready;
    logic [7:0]  dbb_ar_arid;
    logic [3:0]  dbb_ar_arlen;
    logic [63:0] dbb_ar_araddr;
    logic        dbb_r_rvalid, dbb_r_rready;
    logic [7:0]  dbb_r_rid;
    logic        dbb_r_rlast;
    logic [63:0] dbb_r_rdata;
    logic [4:0]  wr_ostd_cnt, rd_ostd_cnt;
    logic        ostd_err;

    nvdla_dbb_ostd_limiter #(.MAX_WR_OSTD(MAX_WR), .MAX_RD_OSTD(MAX_RD)) dut (
        .core_clk(core_clk), .rstn(rstn),
        .core_aw_awvalid(core_aw_awvalid), .core_aw_awready(core_aw_awready),
        .core_aw_awid(core_aw_awid), .core_aw_awlen(core_aw_awlen), .core_aw_awaddr(core_aw_awaddr),
        .core_w_wvalid(core_w_wvalid), .core_w_wready(core_w_wready), .core_w_wdata(core_w_wdata),
        .core_w_wstrb(core_w_wstrb), .core_w_wlast(core_w_wlast),
        .core_b_bvalid(core_b_bvalid), .core_b_bready(core_b_bready), .core_b_bid(core_b_bid),
        .core_ar_arvalid(core_ar_arvalid), .core_ar_arready(core_ar_arready),
        .core_ar_arid(core_ar_arid), .core_ar_arlen(core_ar_arlen), .core_ar_araddr(core_ar_araddr),
        .core_r_rvalid(core_r_rvalid), .core_r_rready(core_r_rready), .core_r_rid(core_r_rid),
        .core_r_rlast(core_r_rlast), .core_r_rdata(core_r_rdata),
        .dbb_aw_awvalid(dbb_aw_awvalid), .dbb_aw_awready(dbb_aw_awready),
        .dbb_aw_awid(dbb_aw_awid), .dbb_aw_awlen(dbb_aw_awlen), .dbb_aw_awaddr(dbb_aw_awaddr),
        .dbb_w_wvalid(dbb_w_wvalid), .dbb_w_wready(dbb_w_wready), .dbb_w_wdata(dbb_w_wdata),
        .dbb_w_wstrb(dbb_w_wstrb), .dbb_w_wlast(dbb_w_wlast),
        .dbb_b_bvalid(dbb_b_bvalid), .dbb_b_bready(dbb_b_bready), .dbb_b_bid(dbb_b_bid),
        .dbb_ar_arvalid(dbb_ar_arvalid), .dbb_ar_arready(dbb_ar_arready),
        .dbb_ar_arid(dbb_ar_arid), .dbb_ar_arlen(dbb_ar_arlen), .dbb_ar_araddr(dbb_ar_araddr),
        .dbb_r_rvalid(dbb_r_rvalid), .dbb_r_rready(dbb_r_rready), .dbb_r_rid(dbb_r_rid),
        .dbb_r_rlast(dbb_r_rlast), .dbb_r_rdata(dbb_r_rdata),
        .wr_ostd_cnt(wr_ostd_cnt), .rd_ostd_cnt(rd_ostd_cnt), .ostd_err(ostd_err)
    );

    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding writes/reads, AWs still owed W data, sticky error.
    int m_wr    = 0;
    int m_rd    = 0;
    int m_wcred = 0;
    bit m_err   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        core_aw_awvalid = 1'b0; core_aw_awid = 8'h0; core_aw_awlen = 4'h0; core_aw_awaddr = 64'h0;
        core_w_wvalid = 1'b0; core_w_wdata = 64'h0; core_w_wstrb = 8'h0; core_w_wlast = 1'b0;
        core_b_bready = 1'b1; core_ar_arvalid = 1'b0; core_ar_arid = 8'h0; core_ar_arlen = 4'h0;
        core_ar_araddr = 64'h0; core_r_rready = 1'b1;
        dbb_aw_awready = 1'b1; dbb_w_wready = 1'b1; dbb_b_bvalid = 1'b0; dbb_b_bid = 8'h0;
        dbb_ar_arready = 1'b1; dbb_r_rvalid = 1'b0; dbb_r_rid = 8'h0; dbb_r_rlast = 1'b0;
        dbb_r_rdata = 64'h0;
    endtask

    task automatic model_clear();
        m_wr = 0; m_rd = 0; m_wcred = 0; m_err = 1'b0;
    endtask

    // Called just after a rising edge with inputs already driven; returns just after the next one.
    task automatic step();
        bit wr_ok, rd_ok, aw_hs, w_ok, wlast_hs, b_hs, ar_hs, rlast_hs;
        #2;
        wr_ok    = rstn && (m_wr < MAX_WR);
        rd_ok    = rstn && (m_rd < MAX_RD);
        aw_hs    = core_aw_awvalid && dbb_aw_awready && wr_ok;
        w_ok     = rstn && (m_wcred > 0 || aw_hs);
        wlast_hs = core_w_wvalid && dbb_w_wready && w_ok && core_w_wlast;
        b_hs     = dbb_b_bvalid && core_b_bready;
        ar_hs    = core_ar_arvalid && dbb_ar_arready && rd_ok;
        rlast_hs = dbb_r_rvalid && core_r_rready && dbb_r_rlast;
        check("aw_gate", {dbb_aw_awvalid, core_aw_awready}, {core_aw_awvalid && wr_ok, dbb_aw_awready && wr_ok});
        check("w_gate", {dbb_w_wvalid, core_w_wready}, {core_w_wvalid && w_ok, dbb_w_wready && w_ok});
        check("ar_gate", {dbb_ar_arvalid, core_ar_arready}, {core_ar_arvalid && rd_ok, dbb_ar_arready && rd_ok});
        check("br_pass", {core_b_bvalid, dbb_b_bready, core_r_rvalid, dbb_r_rready},
              {dbb_b_bvalid, core_b_bready, dbb_r_rvalid, core_r_rready});
        check("aw_payload", {dbb_aw_awid, dbb_aw_awlen, dbb_aw_awaddr[51:0]},
              {core_aw_awid, core_aw_awlen, core_aw_awaddr[51:0]});
        check("awaddr_hi", 64'(dbb_aw_awaddr[63:52]), 64'(core_aw_awaddr[63:52]));
        check("wdata", dbb_w_wdata, core_w_wdata);
        check("wstrb_last", {dbb_w_wstrb, dbb_w_wlast}, {core_w_wstrb, core_w_wlast});
        check("araddr", dbb_ar_araddr, core_ar_araddr);
        check("ar_id_len", {dbb_ar_arid, dbb_ar_arlen}, {core_ar_arid, core_ar_arlen});
        check("rdata", core_r_rdata, dbb_r_rdata);
        check("rid_bid", {core_r_rid, core_r_rlast, core_b_bid}, {dbb_r_rid, dbb_r_rlast, dbb_b_bid});
        @(posedge core_clk);
        if (rstn) begin
            if (b_hs && m_wr == 0) m_err = 1'b1;
            if (rlast_hs && m_rd == 0) m_err = 1'b1;
            if (aw_hs && !b_hs) m_wr++;
            else if (b_hs && !aw_hs && m_wr > 0) m_wr--;
            if (ar_hs && !rlast_hs) m_rd++;
            else if (rlast_hs && !ar_hs && m_rd > 0) m_rd--;
            m_wcred += (aw_hs ? 1 : 0) - (wlast_hs ? 1 : 0);
        end
        #1;
        check("wr_cnt", 64'(wr_ostd_cnt), 64'(m_wr));
        check("rd_cnt", 64'(rd_ostd_cnt), 64'(m_rd));
        check("err", 64'(ostd_err), 64'(m_err));
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        model_clear();
        @(posedge core_clk);
        @(posedge core_clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        // Reset state with requests pending: nothing gated passes, B/R still flow.
        idle();
        core_aw_awvalid = 1'b1; core_w_wvalid = 1'b1; core_ar_arvalid = 1'b1; dbb_b_bvalid = 1'b1;
        #3;
        check("rst_wr_cnt", 64'(wr_ostd_cnt), 64'd0);
        check("rst_rd_cnt", 64'(rd_ostd_cnt), 64'd0);
        check("rst_err", 64'(ostd_err), 64'd0);
        check("rst_gates", {dbb_aw_awvalid, core_aw_awready, dbb_w_wvalid, core_w_wready,
              dbb_ar_arvalid, core_ar_arready}, 64'd0);
        check("rst_b_pass", 64'(core_b_bvalid), 64'd1);
        do_reset();

        // Nine back-to-back AWs against a limit of eight.
        core_aw_awvalid = 1'b1;
        repeat (8) step();
        check("wr_full_cnt", 64'(wr_ostd_cnt), 64'd8);
        check("aw_held", 64'(core_aw_awready), 64'd0);
        step();
        check("aw_still_held", 64'(wr_ostd_cnt), 64'd8);
        dbb_b_bvalid = 1'b1;
        step();
        check("b_frees_slot", 64'(wr_ostd_cnt), 64'd7);
        dbb_b_bvalid = 1'b0;
        #1;
        check("aw_ready_after_b", 64'(core_aw_awready), 64'd1);
        step();
        check("ninth_accepted", 64'(wr_ostd_cnt), 64'd8);

        // AW and B in the same cycle at count 5.
        do_reset();
        core_aw_awvalid = 1'b1;
        repeat (5) step();
        check("cnt_five", 64'(wr_ostd_cnt), 64'd5);
        dbb_b_bvalid = 1'b1;
        step();
        check("aw_b_same_cycle", 64'(wr_ostd_cnt), 64'd5);

        // W presented before its AW.
        do_reset();
        core_w_wvalid = 1'b1; core_w_wdata = 64'h1111_2222_3333_4444; core_w_wstrb = 8'hff;
        repeat (3) begin
            #1;
            check("w_before_aw", 64'(core_w_wready), 64'd0);
            step();
        end
        core_aw_awvalid = 1'b1; core_aw_awlen = 4'd3; core_aw_awaddr = 64'h8000_0000;
        #1;
        check("w_with_aw", 64'(core_w_wready), 64'd1);
        step();
        core_aw_awvalid = 1'b0;
        repeat (2) step();
        core_w_wlast = 1'b1;
        step();
        core_w_wlast = 1'b0;
        #1;
        check("w_blocked_after_last", 64'(core_w_wready), 64'd0);
        step();

        // Randomized traffic; responses only for bursts that exist and whose W has finished.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            core_aw_awvalid = ($urandom_range(0, 3) != 0);
            core_aw_awid    = 8'($urandom);
            core_aw_awlen   = 4'($urandom);
            core_aw_awaddr  = {$urandom, $urandom};
            dbb_aw_awready  = ($urandom_range(0, 3) != 0);
            core_w_wvalid   = $urandom_range(0, 1) == 1;
            core_w_wdata    = {$urandom, $urandom};
            core_w_wstrb    = 8'($urandom);
            core_w_wlast    = ($urandom_range(0, 2) == 0);
            dbb_w_wready    = ($urandom_range(0, 3) != 0);
            dbb_b_bvalid    = (m_wr > m_wcred) && ($urandom_range(0, 2) == 0);
            dbb_b_bid       = 8'($urandom);
            core_b_bready   = $urandom_range(0, 1) == 1;
            core_ar_arvalid = ($urandom_range(0, 3) != 0);
            core_ar_arid    = 8'($urandom);
            core_ar_arlen   = 4'($urandom);
            core_ar_araddr  = {$urandom, $urandom};
            dbb_ar_arready  = ($urandom_range(0, 3) != 0);
            dbb_r_rvalid    = (m_rd > 0) && ($urandom_range(0, 1) == 1);
            dbb_r_rid       = 8'($urandom);
            dbb_r_rlast     = ($urandom_range(0, 2) == 0);
            dbb_r_rdata     = {$urandom, $urandom};
            core_r_rready   = ($urandom_range(0, 3) != 0);
            step();
        end

        // Last R beat with nothing outstanding.
        do_reset();
        dbb_r_rvalid = 1'b1; dbb_r_rlast = 1'b1;
        step();
        check("spurious_r_cnt", 64'(rd_ostd_cnt), 64'd0);
        check("spurious_r_err", 64'(ostd_err), 64'd1);
        idle();
        repeat (3) step();
        check("err_sticky", 64'(ostd_err), 64'd1);

        // Reset with sixteen reads outstanding.
        core_ar_arvalid = 1'b1;
        repeat (16) step();
        check("rd_full_cnt", 64'(rd_ostd_cnt), 64'd16);
        check("ar_held", 64'(core_ar_arready), 64'd0);
        core_aw_awvalid = 1'b1; core_w_wvalid = 1'b1; dbb_b_bvalid = 1'b1; dbb_r_rvalid = 1'b1;
        rstn = 1'b0;
        model_clear();
        #1;
        check("async_wr_cnt", 64'(wr_ostd_cnt), 64'd0);
        check("async_rd_cnt", 64'(rd_ostd_cnt), 64'd0);
        check("async_err", 64'(ostd_err), 64'd0);
        check("async_gates", {dbb_aw_awvalid, core_aw_awready, dbb_w_wvalid, core_w_wready,
              dbb_ar_arvalid, core_ar_arready}, 64'd0);
        check("async_br_pass", {core_b_bvalid, core_r_rvalid}, 64'd3);
        step();
        idle();
        rstn = 1'b1;
        core_ar_arvalid = 1'b1;
        #1;
        check("ar_ready_after_rst", 64'(core_ar_arready), 64'd1);
        step();
        check("ar_accepted_after_rst", 64'(rd_ostd_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
